wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage plus architectural register file for the 5-stage pipeline. It sits directly downstream of the MEM/WB pipeline register and consumes its outputs. It extends load data, selects the writeback value, and commits it into a 32×32 register file. It serves the two combinational read ports used by decode and keeps a retired-instruction counter.

## Interface

**Parameters**
- `LINK_OFFSET`, default 8: byte offset added to `PC_WB` for link writes (jal/jalr/bal).
- `COUNT_WIDTH`, default 32: width of the retired-instruction counter.

**Ports**
- `clock` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `RegWrite_WB` input 1: commit enable.
- `WriteRegDataSignal_WB` input 2: writeback source select.
- `ReadMemData_WB` input 32: raw aligned memory word.
- `AluResult_WB` input 32: ALU result; bits [1:0] give the load byte offset.
- `WriteRegAddr_WB` input 5: destination register.
- `Instruction_WB` input 32: instruction in WB; all-zero means bubble.
- `ReadMemExtSignal_WB` input 4: load width/extension select.
- `PC_WB` input 32: PC of the instruction in WB.
- `ReadRegAddr1_ID` input 5: rs read address.
- `ReadRegAddr2_ID` input 5: rt read address.
- `ReadRegData1_ID` output 32: rs data, combinational.
- `ReadRegData2_ID` output 32: rt data, combinational.
- `WriteRegData_WB` output 32: final writeback value, combinational; also used for forwarding.
- `RetiredCount` output COUNT_WIDTH: number of committed non-bubble instructions, registered.

## Operation

**Load extension**
- Little-endian addressing. Byte lane = `AluResult_WB[1:0]`; half lane = `AluResult_WB[1]`, with bit 0 ignored.
- `ReadMemExtSignal_WB` encoding:
  - 0000: word.
  - 0001: lb, sign-extended.
  - 0010: lbu, zero-extended.
  - 0011: lh, sign-extended.
  - 0100: lhu, zero-extended.
  - Any other value: treated as word.

**Writeback select** (`WriteRegDataSignal_WB`)
- 00: `AluResult_WB`.
- 01: extended load data.
- 10: `PC_WB + LINK_OFFSET`, modulo 2^32.
- 11: reserved; behaves as 00.

**Register file**
- 32 entries; register 0 reads 0 at all times.
- Write occurs at the rising edge when `RegWrite_WB`=1 and `WriteRegAddr_WB`≠0. Writes to register 0 are dropped silently.
- Read ports are purely combinational from the array, plus bypass when configured.

**Retired counter**
- Increments by 1 at each edge where `Instruction_WB`≠0, regardless of `RegWrite_WB`, so stores and branches count.
- Wraps from 2^COUNT_WIDTH−1 to 0 with no flag.

## Timing

- **Reset:** on a rising edge with `reset`=1, all 32 registers and `RetiredCount` clear to 0. No write and no count occurs that cycle, even if `RegWrite_WB`=1.
- **After reset:** `ReadRegData1_ID`/`ReadRegData2_ID` read 0 for every address. `WriteRegData_WB` follows its inputs combinationally and is not gated by reset.
- **Reset mid-operation:** the in-flight WB instruction is discarded entirely. The cycle after reset deasserts behaves normally.
- **Write latency:** 1 edge. The new value is visible on the read ports after the edge, or in the same cycle with bypass (see Configuration).
- **Simultaneous same-address reads:** both ports return identical data.
- **Back-to-back writes to one register:** the last edge wins.
- **Counter latency:** `RetiredCount` reflects an instruction one cycle after it is in WB.

## Configuration

- `WB_BYPASS_EN` defined:
  - A read port returns `WriteRegData_WB` when its address equals `WriteRegAddr_WB`, `RegWrite_WB`=1 and the address ≠0.
  - This covers the WB→ID hazard with no stall.
  - Bypass is suppressed while `reset`=1.
- `WB_BYPASS_EN` undefined:
  - Read ports return the stored array value only, which is stale by one cycle for a same-cycle write.
  - The hazard unit must stall or forward instead.

## Test plan

- **lb sign-extension:** `ReadMemData_WB`=0x80FF7F01, `AluResult_WB`=0x1003, ext=0001, sel=01, `RegWrite_WB`=1, addr=5 → `WriteRegData_WB`=0xFFFFFF80. Reading r5 after the edge returns 0xFFFFFF80.
- **lhu / lh halves:** same word, `AluResult_WB`=0x1002.
  - ext=0100 → 0x000080FF.
  - ext=0011 → 0xFFFF80FF.
  - ext=0111 (undefined) → 0x80FF7F01.
- **Link and register 0:**
  - sel=10, `PC_WB`=0x00400010, addr=31 → r31=0x00400018.
  - Same inputs with addr=0 → r0 still reads 0.
  - PC 0xFFFFFFFC → 0x00000004.
- **Bypass:** write 0x12345678 to r7 while `ReadRegAddr1_ID`=7.
  - With `WB_BYPASS_EN`: 0x12345678 in the same cycle.
  - Without it: the old value, then 0x12345678 after the edge.
- **Counter:** 3 non-zero instructions, 1 bubble, then 1 store with `RegWrite_WB`=0 → `RetiredCount`=4. Preload near the wrap point (COUNT_WIDTH=4, 15 instructions, then 1 more) → 0.
- **Reset mid-stream:** assert `reset` for one edge with `RegWrite_WB`=1 to r9 → r9=0 and `RetiredCount`=0. The next write to r9 succeeds normally.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bundles the MEM/WB writeback inputs, the decode read ports and the retired
// counter between the pipeline and wb_regfile.
interface wb_regfile_if #(
  parameter int COUNT_WIDTH = 32
);
  // Writeback-stage inputs from the MEM/WB pipeline register
  logic                   RegWrite_WB;
  logic [1:0]             WriteRegDataSignal_WB;
  logic [31:0]            ReadMemData_WB;
  logic [31:0]            AluResult_WB;
  logic [4:0]             WriteRegAddr_WB;
  logic [31:0]            Instruction_WB;
  logic [3:0]             ReadMemExtSignal_WB;
  logic [31:0]            PC_WB;

  // Decode-stage read ports
  logic [4:0]             ReadRegAddr1_ID;
  logic [4:0]             ReadRegAddr2_ID;
  logic [31:0]            ReadRegData1_ID;
  logic [31:0]            ReadRegData2_ID;

  // Results
  logic [31:0]            WriteRegData_WB;
  logic [COUNT_WIDTH-1:0] RetiredCount;

  modport master (
    output RegWrite_WB, WriteRegDataSignal_WB, ReadMemData_WB, AluResult_WB,
           WriteRegAddr_WB, Instruction_WB, ReadMemExtSignal_WB, PC_WB,
           ReadRegAddr1_ID, ReadRegAddr2_ID,
    input  ReadRegData1_ID, ReadRegData2_ID, WriteRegData_WB, RetiredCount
  );

  modport slave (
    input  RegWrite_WB, WriteRegDataSignal_WB, ReadMemData_WB, AluResult_WB,
           WriteRegAddr_WB, Instruction_WB, ReadMemExtSignal_WB, PC_WB,
           ReadRegAddr1_ID, ReadRegAddr2_ID,
    output ReadRegData1_ID, ReadRegData2_ID, WriteRegData_WB, RetiredCount
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: load extension, writeback select, 32x32 register file and
// retired-instruction counter. Define WB_BYPASS_EN for same-cycle WB->ID bypass.
module wb_regfile #(
  parameter int LINK_OFFSET = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam logic [3:0] EXT_WORD = 4'b0000;
  localparam logic [3:0] EXT_LB   = 4'b0001;
  localparam logic [3:0] EXT_LBU  = 4'b0010;
  localparam logic [3:0] EXT_LH   = 4'b0011;
  localparam logic [3:0] EXT_LHU  = 4'b0100;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  // Little-endian lane pick followed by sign or zero extension; unknown codes pass the word.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  offset,
    input logic [3:0]  ext
  );
    logic        [7:0]  byte_u;
    logic        [15:0] half_u;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    logic        [31:0] result;
    byte_u = word[8*offset +: 8];
    half_u = offset[1] ? word[31:16] : word[15:0];
    byte_s = signed'(byte_u);
    half_s = signed'(half_u);
    ext_s  = '0;
    result = word;
    case (ext)
      EXT_LB: begin
        ext_s  = byte_s;
        result = unsigned'(ext_s);
      end
      EXT_LBU:  result = {24'd0, byte_u};
      EXT_LH: begin
        ext_s  = half_s;
        result = unsigned'(ext_s);
      end
      EXT_LHU:  result = {16'd0, half_u};
      EXT_WORD: result = word;
      default:  result = word;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] link_value(input logic [31:0] pc);
    return pc + 32'(LINK_OFFSET);
  endfunction

  // ---- p0: combinational writeback stage ----
  logic [31:0] ext_data_p0;
  logic [31:0] wb_data_p0;
  logic        wr_en_p0;
  logic        vld_p0;

  assign ext_data_p0 = load_extend(bus.ReadMemData_WB, bus.AluResult_WB[1:0],
                                   bus.ReadMemExtSignal_WB);
  assign vld_p0      = (bus.Instruction_WB != 32'd0);
  assign wr_en_p0    = bus.RegWrite_WB && (bus.WriteRegAddr_WB != 5'd0);

  always_comb begin
    wb_data_p0 = bus.AluResult_WB;
    case (bus.WriteRegDataSignal_WB)
      SEL_MEM:  wb_data_p0 = ext_data_p0;
      SEL_LINK: wb_data_p0 = link_value(bus.PC_WB);
      SEL_ALU:  wb_data_p0 = bus.AluResult_WB;
      default:  wb_data_p0 = bus.AluResult_WB;
    endcase
  end

  assign bus.WriteRegData_WB = wb_data_p0;

  // ---- p1: architectural state committed at the edge ----
  logic [31:0]            rf_p1 [32];
  logic [COUNT_WIDTH-1:0] retired_cnt_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_p1[i] <= 32'd0;
    end else if (wr_en_p0) begin
      rf_p1[bus.WriteRegAddr_WB] <= wb_data_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_cnt_p1 <= '0;
    end else if (vld_p0) begin
      retired_cnt_p1 <= retired_cnt_p1 + COUNT_WIDTH'(1);
    end
  end

  assign bus.RetiredCount = retired_cnt_p1;

  // ---- read ports: array value, optionally bypassed from the current writeback ----
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;

  always_comb begin
    rd1_data = (bus.ReadRegAddr1_ID == 5'd0) ? 32'd0 : rf_p1[bus.ReadRegAddr1_ID];
    rd2_data = (bus.ReadRegAddr2_ID == 5'd0) ? 32'd0 : rf_p1[bus.ReadRegAddr2_ID];
`ifdef WB_BYPASS_EN
    if (!reset && wr_en_p0 && (bus.ReadRegAddr1_ID == bus.WriteRegAddr_WB))
      rd1_data = wb_data_p0;
    if (!reset && wr_en_p0 && (bus.ReadRegAddr2_ID == bus.WriteRegAddr_WB))
      rd2_data = wb_data_p0;
`endif
  end

  assign bus.ReadRegData1_ID = rd1_data;
  assign bus.ReadRegData2_ID = rd2_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: behavioural model checked every cycle plus
// hand-computed literal expectations.
module tb_wb_regfile;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  wb_regfile_if #(.COUNT_WIDTH(32)) bus ();
  wb_regfile_if #(.COUNT_WIDTH(4))  bus4 ();

  wb_regfile #(.LINK_OFFSET(8), .COUNT_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  wb_regfile #(.LINK_OFFSET(8), .COUNT_WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  // Narrow-counter instance sees exactly the same stimulus
  assign bus4.RegWrite_WB           = bus.RegWrite_WB;
  assign bus4.WriteRegDataSignal_WB = bus.WriteRegDataSignal_WB;
  assign bus4.ReadMemData_WB        = bus.ReadMemData_WB;
  assign bus4.AluResult_WB          = bus.AluResult_WB;
  assign bus4.WriteRegAddr_WB       = bus.WriteRegAddr_WB;
  assign bus4.Instruction_WB        = bus.Instruction_WB;
  assign bus4.ReadMemExtSignal_WB   = bus.ReadMemExtSignal_WB;
  assign bus4.PC_WB                 = bus.PC_WB;
  assign bus4.ReadRegAddr1_ID       = bus.ReadRegAddr1_ID;
  assign bus4.ReadRegAddr2_ID       = bus.ReadRegAddr2_ID;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [31:0] m_rf [32];
  int unsigned m_cnt;
  bit          m_ok = 1'b0;

  function automatic logic [31:0] model_wdata();
    logic [31:0] mem, v;
    mem = bus.ReadMemData_WB;
    case (bus.WriteRegDataSignal_WB)
      2'd1: begin
        case (bus.ReadMemExtSignal_WB)
          4'd1: begin
            v = (mem >> (8 * bus.AluResult_WB[1:0])) & 32'hFF;
            if (v >= 32'd128) v = v | 32'hFFFFFF00;
          end
          4'd2: v = (mem >> (8 * bus.AluResult_WB[1:0])) & 32'hFF;
          4'd3: begin
            v = (mem >> (16 * bus.AluResult_WB[1])) & 32'hFFFF;
            if (v >= 32'd32768) v = v | 32'hFFFF0000;
          end
          4'd4: v = (mem >> (16 * bus.AluResult_WB[1])) & 32'hFFFF;
          default: v = mem;
        endcase
      end
      2'd2:    v = bus.PC_WB + 32'd8;
      default: v = bus.AluResult_WB;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (!reset && bus.RegWrite_WB && a == bus.WriteRegAddr_WB) return model_wdata();
`endif
    return m_rf[a];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
      m_cnt <= 0;
      m_ok  <= 1'b1;
    end else if (m_ok) begin
      if (bus.RegWrite_WB && bus.WriteRegAddr_WB != 5'd0)
        m_rf[bus.WriteRegAddr_WB] <= model_wdata();
      if (bus.Instruction_WB != 32'd0) m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    check("wdata", bus.WriteRegData_WB, model_wdata());
    if (m_ok) begin
      check("rd1", bus.ReadRegData1_ID, model_read(bus.ReadRegAddr1_ID));
      check("rd2", bus.ReadRegData2_ID, model_read(bus.ReadRegAddr2_ID));
      check("count", bus.RetiredCount, m_cnt);
      check("count4", {28'd0, bus4.RetiredCount}, m_cnt % 16);
      check("rd1_w4", bus4.ReadRegData1_ID, model_read(bus.ReadRegAddr1_ID));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wb(input logic regw, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [4:0] waddr, input logic [31:0] instr);
    bus.RegWrite_WB           = regw;
    bus.WriteRegDataSignal_WB = sel;
    bus.AluResult_WB          = alu;
    bus.WriteRegAddr_WB       = waddr;
    bus.Instruction_WB        = instr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_wb(1'b0, 2'd0, 32'd0, 5'd0, 32'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_wb(1'b1, 2'd0, 32'hDEAD0009, 5'd9, 32'h1);
    bus.ReadMemData_WB      = 32'd0;
    bus.ReadMemExtSignal_WB = 4'd0;
    bus.PC_WB               = 32'd0;
    bus.ReadRegAddr1_ID     = 5'd9;
    bus.ReadRegAddr2_ID     = 5'd0;
    step();
    step();
    reset = 1'b0;
    set_wb(1'b0, 2'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("reset_r9", bus.ReadRegData1_ID, 32'd0);
    check("reset_cnt", bus.RetiredCount, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegAddr1_ID = 5'(i);
      bus.ReadRegAddr2_ID = 5'(31 - i);
      #1;
      check("reset_rd1", bus.ReadRegData1_ID, 32'd0);
      check("reset_rd2", bus.ReadRegData2_ID, 32'd0);
    end

    // lb sign extension into r5
    bus.ReadMemData_WB      = 32'h80FF7F01;
    bus.ReadMemExtSignal_WB = 4'b0001;
    set_wb(1'b1, 2'd1, 32'h1003, 5'd5, 32'h8CA50003);
    #1;
    check("lb_wdata", bus.WriteRegData_WB, 32'hFFFFFF80);
    step();
    set_wb(1'b0, 2'd1, 32'h1002, 5'd0, 32'd0);
    bus.ReadRegAddr1_ID = 5'd5;
    bus.ReadRegAddr2_ID = 5'd5;
    #1;
    check("lb_r5", bus.ReadRegData1_ID, 32'hFFFFFF80);
    check("lb_r5_p2", bus.ReadRegData2_ID, 32'hFFFFFF80);

    // Halfword lanes and undefined extension code
    bus.ReadMemExtSignal_WB = 4'b0100; #1;
    check("lhu", bus.WriteRegData_WB, 32'h000080FF);
    bus.ReadMemExtSignal_WB = 4'b0011; #1;
    check("lh", bus.WriteRegData_WB, 32'hFFFF80FF);
    bus.ReadMemExtSignal_WB = 4'b0111; #1;
    check("ext_undef", bus.WriteRegData_WB, 32'h80FF7F01);
    bus.ReadMemExtSignal_WB = 4'b0010; bus.AluResult_WB = 32'h1001; #1;
    check("lbu", bus.WriteRegData_WB, 32'h0000007F);
    bus.ReadMemExtSignal_WB = 4'b0011; bus.AluResult_WB = 32'h1001; #1;
    check("lh_bit0_ignored", bus.WriteRegData_WB, 32'h00007F01);
    step();

    // Link writes and register 0
    bus.PC_WB = 32'h00400010;
    set_wb(1'b1, 2'd2, 32'h0, 5'd31, 32'h0C100000);
    bus.ReadRegAddr1_ID = 5'd31;
    #1;
    check("link_wdata", bus.WriteRegData_WB, 32'h00400018);
    step();
    check("link_r31", bus.ReadRegData1_ID, 32'h00400018);
    bus.WriteRegAddr_WB = 5'd0;
    bus.ReadRegAddr2_ID = 5'd0;
    step();
    check("r0_zero", bus.ReadRegData2_ID, 32'd0);
    bus.PC_WB = 32'hFFFFFFFC;
    #1;
    check("link_wrap", bus.WriteRegData_WB, 32'h00000004);
    step();

    // Reserved select behaves as ALU; back-to-back writes to r3
    set_wb(1'b1, 2'd3, 32'h00000011, 5'd3, 32'h1);
    #1;
    check("sel_rsvd", bus.WriteRegData_WB, 32'h00000011);
    step();
    set_wb(1'b1, 2'd0, 32'h00000022, 5'd3, 32'h1);
    step();
    set_wb(1'b0, 2'd0, 32'h0, 5'd0, 32'h0);
    bus.ReadRegAddr1_ID = 5'd3;
    #1;
    check("b2b_r3", bus.ReadRegData1_ID, 32'h00000022);

    // Same-cycle read of a register being written
    set_wb(1'b1, 2'd0, 32'hAAAA0000, 5'd7, 32'h1);
    step();
    set_wb(1'b1, 2'd0, 32'h12345678, 5'd7, 32'h1);
    bus.ReadRegAddr1_ID = 5'd7;
    bus.ReadRegAddr2_ID = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_rd1", bus.ReadRegData1_ID, 32'h12345678);
    check("bypass_rd2", bus.ReadRegData2_ID, 32'h12345678);
`else
    check("stale_rd1", bus.ReadRegData1_ID, 32'hAAAA0000);
    check("stale_rd2", bus.ReadRegData2_ID, 32'hAAAA0000);
`endif
    step();
    set_wb(1'b0, 2'd0, 32'h0, 5'd0, 32'h0);
    #1;
    check("after_edge_r7", bus.ReadRegData1_ID, 32'h12345678);

    // Counter: 3 instructions, a bubble, then a store
    do_reset();
    set_wb(1'b0, 2'd0, 32'h0, 5'd0, 32'h00221020);
    repeat (3) step();
    bus.Instruction_WB = 32'h0;
    step();
    bus.Instruction_WB = 32'hAC220000;
    step();
    check("cnt_four", bus.RetiredCount, 32'd4);

    // 4-bit counter wrap
    do_reset();
    bus.Instruction_WB = 32'h1;
    repeat (15) step();
    check("cnt4_15", {28'd0, bus4.RetiredCount}, 32'd15);
    step();
    check("cnt4_wrap", {28'd0, bus4.RetiredCount}, 32'd0);
    check("cnt32_16", bus.RetiredCount, 32'd16);

    // Reset mid-stream discards the in-flight write to r9
    set_wb(1'b1, 2'd0, 32'h00000033, 5'd9, 32'h1);
    bus.ReadRegAddr1_ID = 5'd9;
    step();
    check("pre_r9", bus.ReadRegData1_ID, 32'h00000033);
    reset = 1'b1;
    bus.AluResult_WB = 32'h00000055;
    step();
    reset = 1'b0;
    bus.AluResult_WB = 32'h00000099;
    bus.RegWrite_WB  = 1'b0;
    bus.Instruction_WB = 32'h0;
    #1;
    check("rst_r9", bus.ReadRegData1_ID, 32'd0);
    check("rst_cnt", bus.RetiredCount, 32'd0);
    set_wb(1'b1, 2'd0, 32'h00000099, 5'd9, 32'h1);
    step();
    set_wb(1'b0, 2'd0, 32'h0, 5'd0, 32'h0);
    #1;
    check("post_rst_r9", bus.ReadRegData1_ID, 32'h00000099);
    check("post_rst_cnt", bus.RetiredCount, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
